// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/decode control, instruction memory port and IF/ID outputs.
// The slave modport is the fetch stage's view.
interface fetch_stage_if;
    logic        stall_f;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic [31:0] fetch_count;

    modport master (
        output stall_f, branch_taken, branch_target, jump, jump_index, imem_rdata,
        input  imem_addr, pc_f, instr_d, pcplus4_d, valid_d, fetch_count
    );

    modport slave (
        input  stall_f, branch_taken, branch_target, jump, jump_index, imem_rdata,
        output imem_addr, pc_f, instr_d, pcplus4_d, valid_d, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: program counter, IF/ID pipeline register and fetch counter,
// with hazard stalls and jump/branch redirects that squash the wrong-path instruction.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_vld_q, ifid_vld_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] pcplus4_f;
    logic [31:0] jump_tgt;
    logic [31:0] br_tgt;
    logic        redirect;

    assign pcplus4_f = pc_q + 32'd4;
    assign jump_tgt  = {ifid_pc4_q[31:28], bus.jump_index, 2'b00};
    assign br_tgt    = {bus.branch_target[31:2], 2'b00};
    assign redirect  = bus.jump | bus.branch_taken;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_vld_d   = ifid_vld_q;
        cnt_d        = cnt_q;

        // Jump is resolved ahead of branch; either redirect overrides a stall.
        if (bus.jump) begin
            pc_d = jump_tgt;
        end else if (bus.branch_taken) begin
            pc_d = br_tgt;
        end else if (!bus.stall_f) begin
            pc_d = pcplus4_f;
        end

        if (redirect) begin
            ifid_instr_d = 32'd0;
            ifid_pc4_d   = 32'd0;
            ifid_vld_d   = 1'b0;
        end else if (!bus.stall_f) begin
            ifid_instr_d = bus.imem_rdata;
            ifid_pc4_d   = pcplus4_f;
            ifid_vld_d   = 1'b1;
            cnt_d        = cnt_q + 32'd1;
        end

        unique case (state_q)
            BOOT: begin
                if (redirect || !bus.stall_f) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_vld_q   <= 1'b0;
            cnt_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_vld_q   <= ifid_vld_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc_f        = pc_q;
    assign bus.instr_d     = ifid_instr_q;
    assign bus.pcplus4_d   = ifid_pc4_q;
    assign bus.valid_d     = ifid_vld_q;
    assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, branch, jump priority, PC wrap and async reset.
module tb_fetch_stage;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    fetch_stage_if bus_a ();
    fetch_stage_if bus_w ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w.slave)
    );

    // Instruction memory image: word i holds 0x1000_0000 + i.
    assign bus_a.imem_rdata = 32'h1000_0000 + {2'b00, bus_a.imem_addr[31:2]};
    assign bus_w.imem_rdata = 32'h1000_0000 + {2'b00, bus_w.imem_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] pc4, input logic vld, input logic [31:0] cnt);
        chk({tag, ".pc_f"},        bus_a.pc_f, pc);
        chk({tag, ".imem_addr"},   bus_a.imem_addr, pc);
        chk({tag, ".instr_d"},     bus_a.instr_d, instr);
        chk({tag, ".pcplus4_d"},   bus_a.pcplus4_d, pc4);
        chk({tag, ".valid_d"},     {31'd0, bus_a.valid_d}, {31'd0, vld});
        chk({tag, ".fetch_count"}, bus_a.fetch_count, cnt);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus_a.stall_f = 1'b0; bus_a.branch_taken = 1'b0; bus_a.branch_target = 32'd0;
        bus_a.jump = 1'b0;    bus_a.jump_index = 26'd0;
        bus_w.stall_f = 1'b0; bus_w.branch_taken = 1'b0; bus_w.branch_target = 32'd0;
        bus_w.jump = 1'b0;    bus_w.jump_index = 26'd0;

        #3;
        chk_a("rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("rst_w.pc_f", bus_w.pc_f, 32'hFFFF_FFFC);

        @(negedge clk);
        reset = 1'b0;

        // Boot: first edge fetches RESET_PC
        step();
        chk_a("boot1", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd1);
        chk("wrap1.pc_f", bus_w.pc_f, 32'h0);
        chk("wrap1.pcplus4_d", bus_w.pcplus4_d, 32'h0);
        chk("wrap1.instr_d", bus_w.instr_d, 32'h4FFF_FFFF);
        step();
        chk_a("boot2", 32'h8, 32'h1000_0001, 32'h8, 1'b1, 32'd2);
        chk("wrap2.pc_f", bus_w.pc_f, 32'h4);

        // Stall three edges at pc_f = 8
        bus_a.stall_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("stall", 32'h8, 32'h1000_0001, 32'h8, 1'b1, 32'd2);
        end
        bus_a.stall_f = 1'b0;
        step();
        chk_a("resume1", 32'hC, 32'h1000_0002, 32'hC, 1'b1, 32'd3);
        step();
        chk_a("resume2", 32'h10, 32'h1000_0003, 32'h10, 1'b1, 32'd4);

        // Taken branch at pc_f = 0x10, low target bits ignored
        bus_a.branch_taken = 1'b1; bus_a.branch_target = 32'h0000_0043;
        step();
        chk_a("br_bubble", 32'h40, 32'h0, 32'h0, 1'b0, 32'd4);
        bus_a.branch_taken = 1'b0;
        step();
        chk_a("br_target", 32'h44, 32'h1000_0010, 32'h44, 1'b1, 32'd5);

        // Move to 0x1000_0004 so pcplus4_d becomes 0x1000_0008
        bus_a.branch_taken = 1'b1; bus_a.branch_target = 32'h1000_0004;
        step();
        chk_a("br2_bubble", 32'h1000_0004, 32'h0, 32'h0, 1'b0, 32'd5);
        bus_a.branch_taken = 1'b0;
        step();
        chk_a("br2_target", 32'h1000_0008, 32'h1400_0001, 32'h1000_0008, 1'b1, 32'd6);

        // Jump + branch + stall together: jump wins, stall overridden
        bus_a.jump = 1'b1; bus_a.jump_index = 26'h000_0100;
        bus_a.branch_taken = 1'b1; bus_a.branch_target = 32'h0000_0080;
        bus_a.stall_f = 1'b1;
        step();
        chk_a("jmp_bubble", 32'h1000_0400, 32'h0, 32'h0, 1'b0, 32'd6);
        bus_a.jump = 1'b0; bus_a.branch_taken = 1'b0; bus_a.stall_f = 1'b0;
        step();
        chk_a("jmp_target", 32'h1000_0404, 32'h1400_0100, 32'h1000_0404, 1'b1, 32'd7);

        // Async reset mid-cycle during a branch redirect
        bus_a.branch_taken = 1'b1; bus_a.branch_target = 32'h0000_0200;
        #3;
        reset = 1'b1;
        #1;
        chk_a("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        bus_a.branch_taken = 1'b0;
        step();
        chk_a("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Stall in BOOT keeps everything parked
        bus_a.stall_f = 1'b1;
        step();
        chk_a("boot_stall", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        bus_a.stall_f = 1'b0;
        step();
        chk_a("reboot1", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
